clk_div_sched: RTL and testbench

- Run-time controller for the board's square-wave clock divider. Owns a single half-period counter and sequences it through idle, run and pause.
- Accepts new divide ratios over a valid/ready handshake and applies them only at a half-period boundary, so the output never glitches.
- Produces a 50%-duty enable clock and a one-cycle tick for downstream counters (seconds, display scan).
- Sits between the top-level control logic (buttons/FSM) and the timekeeping logic; all outputs are synchronous to clk.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_core.sv | 53 +++++
 rtl/clk_div_sched.sv | 122 ++++++++++++
 tb/tb_clk_div_sched.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the run-time square-wave divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int DEF_CLK_HZ = 100_000_000;

    // Half-period that yields a 1 Hz output from the given input clock.
    function automatic int half_of(input int hz);
        return hz / 2;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter with toggle and rising-edge tick generation.
module clk_div_core #(
    parameter int CW = 27
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic          cnt_clr,
    input  logic [CW-1:0] half,
    output logic [CW-1:0] cnt,
    output logic          boundary,
    output logic          clk_out,
    output logic          tick
);

    logic [CW-1:0] cnt_reg;
    logic          clk_out_reg;
    logic          tick_reg;

    assign boundary = (cnt_reg == half - CW'(1));
    assign cnt      = cnt_reg;
    assign clk_out  = clk_out_reg;
    assign tick     = tick_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
        end else if (clr) begin
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
        end else if (en) begin
            if (boundary) begin
                cnt_reg     <= '0;
                clk_out_reg <= ~clk_out_reg;
                // Tick only accompanies the 0->1 transition.
                tick_reg    <= ~clk_out_reg;
            end else begin
                cnt_reg  <= cnt_reg + CW'(1);
                tick_reg <= 1'b0;
            end
        end else begin
            tick_reg <= 1'b0;
            if (cnt_clr) begin
                cnt_reg <= '0;
            end
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Idle/run/pause sequencer and glitch-free ratio update around clk_div_core.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int CW       = 27,
    parameter int DEF_HALF = half_of(CLK_HZ)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          pause,
    input  logic          stop,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_half,
    output logic          cfg_ready,
    output logic          cfg_err,
    output logic          clk_out,
    output logic          tick,
    output logic          running
);

    state_t        state_reg, state_next;
    logic [CW-1:0] half_reg;
    logic [CW-1:0] pend_reg;
    logic          pend_valid_reg;
    logic          cfg_err_reg;
    logic [CW-1:0] cnt;
    logic          boundary;
    logic          en, clr, cnt_clr, apply;
    logic          xfer;

    assign cfg_ready = ~pend_valid_reg;
    assign cfg_err   = cfg_err_reg;
    assign running   = (state_reg == ST_RUN);
    assign xfer      = cfg_valid && cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        en         = 1'b0;
        clr        = 1'b0;
        cnt_clr    = 1'b0;
        apply      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                clr   = 1'b1;
                apply = pend_valid_reg;
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    clr        = 1'b1;
                end else if (pause) begin
                    state_next = ST_PAUSE;
                end else begin
                    en    = 1'b1;
                    // Swap ratios only where the old half-period ends.
                    apply = pend_valid_reg && boundary;
                end
            end
            ST_PAUSE: begin
                apply   = pend_valid_reg;
                cnt_clr = pend_valid_reg && (cnt >= pend_reg - CW'(1));
                if (stop) begin
                    state_next = ST_IDLE;
                    clr        = 1'b1;
                end else if (start) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
                clr        = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_reg       <= CW'(DEF_HALF);
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            cfg_err_reg <= xfer && (cfg_half == '0);
            if (apply) begin
                half_reg       <= pend_reg;
                pend_valid_reg <= 1'b0;
            end else if (xfer && (cfg_half != '0)) begin
                pend_reg       <= cfg_half;
                pend_valid_reg <= 1'b1;
            end
        end
    end

    clk_div_core #(
        .CW(CW)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .cnt_clr  (cnt_clr),
        .half     (half_reg),
        .cnt      (cnt),
        .boundary (boundary),
        .clk_out  (clk_out),
        .tick     (tick)
    );

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched with half-period 3: vector table plus corner sequences.
module tb_clk_div_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_half = 8'd0;
    logic       cfg_ready, cfg_err, clk_out, tick, running;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs packed as {clk_out, tick, running, cfg_ready, cfg_err}.
    logic [4:0] sb_q[$];

    typedef struct {
        logic       start;
        logic       pause;
        logic       stop;
        logic       cfg_valid;
        logic [7:0] cfg_half;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[17];

    always #5 clk = ~clk;

    clk_div_sched #(
        .CLK_HZ   (100),
        .CW       (8),
        .DEF_HALF (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running)
    );

    function automatic vec_t mk(input logic s, input logic cv, input logic [7:0] ch,
                                input logic [4:0] e);
        vec_t v;
        v.start = s; v.pause = 1'b0; v.stop = 1'b0;
        v.cfg_valid = cv; v.cfg_half = ch; v.exp = e;
        return v;
    endfunction

    task automatic check_out(input string name);
        logic [4:0] got, want;
        got = {clk_out, tick, running, cfg_ready, cfg_err};
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: scoreboard empty, got %b", name, got);
        end else begin
            want = sb_q.pop_front();
            if (got !== want) begin
                n_errors++;
                $display("FAIL %s: co/tk/run/rdy/err got %b expected %b", name, got, want);
            end else begin
                $display("ok   %s: %b", name, got);
            end
        end
    endtask

    task automatic cyc(input logic s, input logic p, input logic t, input logic cv,
                       input logic [7:0] ch, input logic [4:0] exp, input string name);
        start = s; pause = p; stop = t; cfg_valid = cv; cfg_half = ch;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        check_out(name);
        start = 1'b0; pause = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_half = 8'd0;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        start = 1'b0; pause = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_half = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(5'b00010);
        check_out(name);
        rst_n = 1'b1;
    endtask

    initial begin
        // Start at edge 0; rises at 3 and 9, falls at 6; zero config at 10 only flags error.
        tbl[0]  = mk(1'b1, 1'b0, 8'd0, 5'b00110);
        tbl[1]  = mk(1'b0, 1'b0, 8'd0, 5'b00110);
        tbl[2]  = mk(1'b0, 1'b0, 8'd0, 5'b00110);
        tbl[3]  = mk(1'b0, 1'b0, 8'd0, 5'b11110);
        tbl[4]  = mk(1'b0, 1'b0, 8'd0, 5'b10110);
        tbl[5]  = mk(1'b0, 1'b0, 8'd0, 5'b10110);
        tbl[6]  = mk(1'b0, 1'b0, 8'd0, 5'b00110);
        tbl[7]  = mk(1'b0, 1'b0, 8'd0, 5'b00110);
        tbl[8]  = mk(1'b0, 1'b0, 8'd0, 5'b00110);
        tbl[9]  = mk(1'b0, 1'b0, 8'd0, 5'b11110);
        tbl[10] = mk(1'b0, 1'b1, 8'd0, 5'b10111);
        tbl[11] = mk(1'b0, 1'b0, 8'd0, 5'b10110);
        tbl[12] = mk(1'b0, 1'b0, 8'd0, 5'b00110);
        tbl[13] = mk(1'b0, 1'b0, 8'd0, 5'b00110);
        tbl[14] = mk(1'b0, 1'b0, 8'd0, 5'b00110);
        tbl[15] = mk(1'b0, 1'b0, 8'd0, 5'b11110);
        tbl[16] = mk(1'b0, 1'b0, 8'd0, 5'b10110);

        do_reset("reset_a");
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].start, tbl[i].pause, tbl[i].stop, tbl[i].cfg_valid,
                tbl[i].cfg_half, tbl[i].exp, $sformatf("table_e%0d", i));
        end

        // Pause with cnt=1, clk_out=1; resume toggles after two RUN edges, no tick.
        do_reset("reset_b");
        cyc(1, 0, 0, 0, 0, 5'b00110, "pause_e0");
        for (int i = 1; i < 3; i++) cyc(0, 0, 0, 0, 0, 5'b00110, $sformatf("pause_e%0d", i));
        cyc(0, 0, 0, 0, 0, 5'b11110, "pause_e3");
        cyc(0, 0, 0, 0, 0, 5'b10110, "pause_e4");
        for (int i = 5; i < 15; i++) cyc(0, 1, 0, 0, 0, 5'b10010, $sformatf("pause_hold_e%0d", i));
        cyc(1, 0, 0, 0, 0, 5'b10110, "resume_e15");
        cyc(0, 0, 0, 0, 0, 5'b10110, "resume_e16");
        cyc(0, 0, 0, 0, 0, 5'b00110, "resume_e17");
        cyc(0, 0, 0, 0, 0, 5'b00110, "resume_e18");
        cyc(0, 0, 0, 0, 0, 5'b00110, "resume_e19");
        cyc(0, 0, 0, 0, 0, 5'b11110, "resume_e20");

        // Ratio 3 -> 5 offered at edge 4, applied at boundary edge 6.
        do_reset("reset_c");
        cyc(1, 0, 0, 0, 0, 5'b00110, "cfg_e0");
        for (int i = 1; i < 3; i++) cyc(0, 0, 0, 0, 0, 5'b00110, $sformatf("cfg_e%0d", i));
        cyc(0, 0, 0, 0, 0, 5'b11110, "cfg_e3");
        cyc(0, 0, 0, 1, 8'd5, 5'b10100, "cfg_e4");
        cyc(0, 0, 0, 0, 0, 5'b10100, "cfg_e5");
        cyc(0, 0, 0, 0, 0, 5'b00110, "cfg_e6");
        for (int i = 7; i < 11; i++) cyc(0, 0, 0, 0, 0, 5'b00110, $sformatf("cfg_e%0d", i));
        cyc(0, 0, 0, 0, 0, 5'b11110, "cfg_e11");
        for (int i = 12; i < 16; i++) cyc(0, 0, 0, 0, 0, 5'b10110, $sformatf("cfg_e%0d", i));
        cyc(0, 0, 0, 0, 0, 5'b00110, "cfg_e16");

        // stop beats pause; restart shows the counter was cleared.
        do_reset("reset_d");
        cyc(1, 0, 0, 0, 0, 5'b00110, "stop_e0");
        for (int i = 1; i < 3; i++) cyc(0, 0, 0, 0, 0, 5'b00110, $sformatf("stop_e%0d", i));
        cyc(0, 0, 0, 0, 0, 5'b11110, "stop_e3");
        cyc(0, 0, 0, 0, 0, 5'b10110, "stop_e4");
        cyc(0, 1, 1, 0, 0, 5'b00010, "stop_pause_e5");
        cyc(1, 0, 0, 0, 0, 5'b00110, "restart_e6");
        cyc(0, 0, 0, 0, 0, 5'b00110, "restart_e7");
        cyc(0, 0, 0, 0, 0, 5'b00110, "restart_e8");
        cyc(0, 0, 0, 0, 0, 5'b11110, "restart_e9");

        // Asynchronous reset with a pending ratio of 7; afterwards spacing is 3 again.
        do_reset("reset_e");
        cyc(1, 0, 0, 0, 0, 5'b00110, "arst_e0");
        for (int i = 1; i < 3; i++) cyc(0, 0, 0, 0, 0, 5'b00110, $sformatf("arst_e%0d", i));
        cyc(0, 0, 0, 0, 0, 5'b11110, "arst_e3");
        cyc(0, 0, 0, 1, 8'd7, 5'b10100, "arst_pend_e4");
        #2 rst_n = 1'b0;
        #1;
        sb_q.push_back(5'b00010);
        check_out("arst_now");
        #2 rst_n = 1'b1;
        cyc(1, 0, 0, 0, 0, 5'b00110, "post_e0");
        for (int i = 1; i < 3; i++) cyc(0, 0, 0, 0, 0, 5'b00110, $sformatf("post_e%0d", i));
        cyc(0, 0, 0, 0, 0, 5'b11110, "post_e3");
        cyc(0, 0, 0, 0, 0, 5'b10110, "post_e4");
        cyc(0, 0, 0, 0, 0, 5'b10110, "post_e5");
        cyc(0, 0, 0, 0, 0, 5'b00110, "post_e6");
        cyc(0, 0, 0, 0, 0, 5'b00110, "post_e7");
        cyc(0, 0, 0, 0, 0, 5'b00110, "post_e8");
        cyc(0, 0, 0, 0, 0, 5'b11110, "post_e9");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
